// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result handshake bundle between a seq_alu and its user.
//   in_valid/in_ready       request handshake (master -> slave)
//   operand_a/operand_b     operands, alu_control opcode
//   out_valid/out_ready     result handshake (slave -> master)
//   alu_result              registered result, alu_zero_flag result-is-zero
//   busy                    slave is iterating a multiply/divide
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_control;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero_flag;
    logic            busy;

    modport master (
        output in_valid, operand_a, operand_b, alu_control, out_ready,
        input  in_ready, out_valid, alu_result, alu_zero_flag, busy
    );

    modport slave (
        input  in_valid, operand_a, operand_b, alu_control, out_ready,
        output in_ready, out_valid, alu_result, alu_zero_flag, busy
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential RV-style ALU with IDLE/BUSY/DONE handshake FSM.
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   bus      seq_alu_if.slave: request in (in_valid/in_ready, operands,
//            alu_control), result out (out_valid/out_ready, alu_result,
//            alu_zero_flag), busy
// Opcodes 0-9 complete in one cycle. Build with SEQ_ALU_MULDIV_EN defined to
// get iterative MUL/MULHU/DIV/DIVU/REM/REMU; otherwise opcodes 10-15 return 0.
module seq_alu #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic            out_valid;
    logic            zero;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] fast;
    logic [3:0]      op;
    logic [SW-1:0]   sh;
    logic            accept;

    assign a                 = bus.operand_a;
    assign b                 = bus.operand_b;
    assign op                = bus.alu_control;
    assign sh                = b[SW-1:0];
    assign accept            = bus.in_valid && state == IDLE;
    assign bus.in_ready      = state == IDLE;
    assign bus.out_valid     = out_valid;
    assign bus.alu_result    = res;
    assign bus.alu_zero_flag = zero;

`ifdef SEQ_ALU_MULDIV_EN
    logic              busy;
    logic [SW-1:0]     cnt;
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   m;
    logic [3:0]        op_q;
    logic              neg;
    logic              dz;
    logic              ovf;
    logic              slow;
    logic              mul;
    logic              sgn;
    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shr;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_nxt;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] nxt;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   fin;

    assign bus.busy = busy;
    assign dz       = b == '0;
    assign ovf      = a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    assign mul      = op[3:1] == 3'b101;
    assign sgn      = op[3:2] == 2'b11 && !op[0];
    // Divides by zero and signed overflow resolve in one cycle.
    assign slow     = mul || (op[3:2] == 2'b11 && !dz && !(sgn && ovf));
    assign ma       = sgn && a[XLEN-1] ? -a : a;
    assign mb       = sgn && b[XLEN-1] ? -b : b;

    // p holds {high product, multiplier} for multiplies and
    // {partial remainder, dividend/quotient} for divides; m is the
    // multiplicand or divisor magnitude.
    assign sum     = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    assign mul_nxt = {sum, p[XLEN-1:1]};
    assign shr     = p[2*XLEN-1:XLEN-1];
    assign diff    = shr - {1'b0, m};
    assign div_nxt = diff[XLEN] ? {shr[XLEN-1:0], p[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    assign nxt     = op_q[3:1] == 3'b101 ? mul_nxt : div_nxt;
    assign raw     = op_q[3:1] == 3'b101 ? (op_q[0] ? nxt[2*XLEN-1:XLEN] : nxt[XLEN-1:0])
                                         : (op_q[1] ? nxt[2*XLEN-1:XLEN] : nxt[XLEN-1:0]);
    assign fin     = neg ? -raw : raw;
`else
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        fast = '0;
        case (op)
            4'd0:    fast = a + b;
            4'd1:    fast = a - b;
            4'd2:    fast = a << sh;
            4'd3:    fast = a >> sh;
            4'd4:    fast = $signed(a) >>> sh;
            4'd5:    fast = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'd6:    fast = {{(XLEN-1){1'b0}}, a < b};
            4'd7:    fast = a & b;
            4'd8:    fast = a | b;
            4'd9:    fast = a ^ b;
`ifdef SEQ_ALU_MULDIV_EN
            // Only the early-out cases reach the result from here.
            4'd12:   fast = dz ? '1 : a;
            4'd13:   fast = '1;
            4'd14:   fast = dz ? a : '0;
            4'd15:   fast = a;
`endif
            default: fast = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            zero      <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            busy      <= 1'b0;
            cnt       <= '0;
            p         <= '0;
            m         <= '0;
            op_q      <= '0;
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef SEQ_ALU_MULDIV_EN
                    if (accept && slow) begin
                        state <= BUSY;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        op_q  <= op;
                        m     <= mul ? a : mb;
                        p     <= {{XLEN{1'b0}}, mul ? b : ma};
                        neg   <= sgn && (op[1] ? a[XLEN-1] : a[XLEN-1] ^ b[XLEN-1]);
                    end else if (accept) begin
`else
                    if (accept) begin
`endif
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res       <= fast;
                        zero      <= fast == '0;
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                BUSY: begin
                    p   <= nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == SW'(XLEN - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        res       <= fin;
                        zero      <= fin == '0;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        zero      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; legal values are powers of two from 8 to 64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: operand_a  input  XLEN  first operand (rs1).
REQ-007 Port: operand_b  input  XLEN  second operand (rs2/imm).
REQ-008 Port: alu_control  input  4  opcode: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 SLT, 6 SLTU, 7 AND, 8 OR, 9 XOR, 10 MUL, 11 MULHU, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: alu_result  output  XLEN  registered result.
REQ-012 Port: alu_zero_flag  output  1  high when alu_result is all zeros while out_valid is high.
REQ-013 Port: busy  output  1  high while in state BUSY.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE; in_ready = (state==IDLE).
REQ-015 Accept = in_valid && in_ready; operands and opcode SHALL be captured on accept, and later input changes SHALL have no effect.
REQ-016 Opcodes 0-9 SHALL move IDLE->DONE on accept, so out_valid rises on the next cycle (latency 1).
REQ-017 Shift amounts SHALL be operand_b[log2(XLEN)-1:0]; SRA SHALL sign-fill; SLT/SLTU SHALL return 1 or 0, zero-extended.
REQ-018 MUL and MULHU SHALL be iterative shift-add, one bit per cycle: IDLE->BUSY for XLEN cycles, then DONE; latency = XLEN+1 cycles.
REQ-019 MUL SHALL return the low XLEN bits of the 2*XLEN-bit product; MULHU SHALL return the high XLEN bits of the unsigned product.
REQ-020 DIV/DIVU/REM/REMU SHALL use restoring division, one bit per cycle, with signed ops on magnitudes plus sign fix-up; latency = XLEN+1 cycles.
REQ-021 Signed quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero: quotient = all ones, remainder = operand_a; these SHALL resolve with latency 1 (early out).
REQ-023 Signed overflow (operand_a = most negative, operand_b = -1): DIV = operand_a, REM = 0; latency 1.
REQ-024 In DONE, out_valid SHALL be 1; alu_result and alu_zero_flag SHALL hold stable until out_ready is sampled high, then DONE->IDLE.
REQ-025 Back-to-back throughput SHALL be at most one op per two cycles; in_ready SHALL stay low in BUSY and DONE.
REQ-026 When out_valid is low, alu_zero_flag SHALL be 0.

Reset
REQ-027 When rst_n is low at a clk edge: state = IDLE, out_valid = 0, alu_result = 0, alu_zero_flag = 0, busy = 0, and iteration counter and partial registers = 0.
REQ-028 Reset SHALL abort any BUSY or DONE operation with no result delivered; in_ready SHALL be 1 in the first cycle after rst_n goes high.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined: opcodes 10-15 SHALL behave as in REQ-018 to REQ-023.
REQ-030 Macro SEQ_ALU_MULDIV_EN undefined: opcodes 10-15 SHALL return 0 with latency 1; no multiply/divide datapath or BUSY-state logic SHALL be synthesised; busy SHALL be tied to 0.

Verification
REQ-031 XLEN=32, ADD 0x7FFFFFFF + 1 with out_ready=1 -> out_valid one cycle after accept, result 0x80000000, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-032 MULHU 0xFFFFFFFF * 0xFFFFFFFF -> out_valid 33 cycles after accept, result 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-033 DIV -7 / 2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, each 33 cycles; DIVU 100 / 0 -> 0xFFFFFFFF with latency 1; REM 0x80000000 % -1 -> 0 with latency 1.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and zero flag stable and in_ready low; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst_n=0 at cycle 10 of a DIVU -> outputs match REQ-027 on the next edge, and no out_valid pulse occurs.
REQ-036 Run XLEN=8 with random ops checked against a reference model, with SEQ_ALU_MULDIV_EN both defined and undefined.
